// File: rtl/cpu_ctrl.sv
// rtl/cpu_ctrl.sv - multi-cycle fetch/decode/execute/writeback sequencer
module cpu_ctrl #(
  parameter logic [7:0] RESET_PC = 8'h00,
  parameter int         TIMEOUT  = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  output logic        imem_req,
  output logic [7:0]  imem_addr,
  input  logic        imem_ack,
  input  logic [7:0]  imem_data,
  output logic [7:0]  ir,
  output logic [3:0]  rf_raddr,
  output logic        rf_we,
  output logic [3:0]  rf_waddr,
  output logic        alu_start,
  input  logic        alu_done,
  input  logic        zero_flag,
  output logic [2:0]  state,
  output logic        halted,
  output logic        err,
  output logic [15:0] retired
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  // Last EXEC cycle index in which alu_done may still arrive.
  localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_BZ   = 4'hD;
  localparam logic [3:0] OP_JMP  = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  state_t         state_q, state_d;
  logic [7:0]     pc;
  logic [WW-1:0]  wait_cnt;

  logic ir_load, pc_inc, pc_load, ret_inc, wait_inc, err_set;

  // Outputs that follow registered state directly; reset forces them at once.
  assign state     = state_q;
  assign imem_addr = pc;
  assign rf_raddr  = ir[3:0];
  assign halted    = (state_q == S_HALT);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state decode and per-state control strobes.
  always_comb begin
    state_d   = state_q;
    imem_req  = 1'b0;
    alu_start = 1'b0;
    rf_we     = 1'b0;
    rf_waddr  = 4'h0;
    ir_load   = 1'b0;
    pc_inc    = 1'b0;
    pc_load   = 1'b0;
    ret_inc   = 1'b0;
    wait_inc  = 1'b0;
    err_set   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_load = 1'b1;
          pc_inc  = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        case (ir[7:4])
          OP_HALT: state_d = S_HALT;
          OP_JMP: begin
            pc_load = 1'b1;
            ret_inc = 1'b1;
            state_d = S_FETCH;
          end
          OP_BZ: begin
            pc_load = zero_flag;
            ret_inc = 1'b1;
            state_d = S_FETCH;
          end
          OP_NOP: begin
            ret_inc = 1'b1;
            state_d = S_FETCH;
          end
          default: state_d = S_EXEC;
        endcase
      end
      S_EXEC: begin
        // Counter is zero only in the first EXEC cycle.
        alu_start = (wait_cnt == '0);
        if (alu_done) begin
          state_d = S_WB;
        end else if (wait_cnt == WAIT_LAST) begin
          err_set = 1'b1;
          state_d = S_HALT;
        end else begin
          wait_inc = 1'b1;
        end
      end
      S_WB: begin
        rf_we    = 1'b1;
        rf_waddr = ir[3:0];
        ret_inc  = 1'b1;
        state_d  = run ? S_FETCH : S_IDLE;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath registers: pc, instruction, retire count, ALU wait counter, error.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc       <= RESET_PC;
      ir       <= 8'h00;
      retired  <= 16'h0000;
      wait_cnt <= '0;
      err      <= 1'b0;
    end else begin
      if (pc_inc)       pc <= pc + 8'd1;
      else if (pc_load) pc <= {ir[3:0], 4'h0};
      if (ir_load) ir <= imem_data;
      if (ret_inc) retired <= retired + 16'd1;
      // Any cycle that does not extend an ALU wait returns the counter to 0,
      // so it is always 0 on EXEC entry.
      wait_cnt <= wait_inc ? wait_cnt + 1'b1 : '0;
      if (err_set) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cpu_ctrl.sv
// tb/tb_cpu_ctrl.sv - scoreboard bench for cpu_ctrl with random programs
module tb_cpu_ctrl;
  localparam int TO = 15;
  localparam int K_FETCH = 0;
  localparam int K_WB    = 1;
  localparam int K_HALT  = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, run, imem_req, imem_ack, rf_we, alu_start, alu_done, zero_flag, halted, err;
  logic [7:0]  imem_addr, imem_data, ir;
  logic [3:0]  rf_raddr, rf_waddr;
  logic [2:0]  state;
  logic [15:0] retired;

  logic        w_run, w_imem_req, w_rf_we, w_alu_start, w_halted, w_err;
  logic [7:0]  w_imem_addr, w_ir;
  logic [3:0]  w_rf_raddr, w_rf_waddr;
  logic [2:0]  w_state;
  logic [15:0] w_retired;

  cpu_ctrl #(.RESET_PC(8'h00), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .run(run), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_data(imem_data), .ir(ir), .rf_raddr(rf_raddr), .rf_we(rf_we),
    .rf_waddr(rf_waddr), .alu_start(alu_start), .alu_done(alu_done), .zero_flag(zero_flag),
    .state(state), .halted(halted), .err(err), .retired(retired));

  // Second instance: RESET_PC at the top of the address space, every fetch is a NOP.
  cpu_ctrl #(.RESET_PC(8'hFF), .TIMEOUT(TO)) u_wrap (
    .clk(clk), .reset(reset), .run(w_run), .imem_req(w_imem_req), .imem_addr(w_imem_addr),
    .imem_ack(1'b1), .imem_data(8'h00), .ir(w_ir), .rf_raddr(w_rf_raddr), .rf_we(w_rf_we),
    .rf_waddr(w_rf_waddr), .alu_start(w_alu_start), .alu_done(1'b0), .zero_flag(1'b0),
    .state(w_state), .halted(w_halted), .err(w_err), .retired(w_retired));

  typedef struct { int kind; int val; int ret; } ev_t;
  ev_t sbq[$];
  ev_t mon_e;

  logic [7:0] mem [256];
  int  lat_tab [64];
  bit  zf_tab [64];
  int  f_idx, ex_idx;
  int  n_chk, n_fail;
  bit  sb_on, halt_seen;
  logic [2:0] prev_state;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Instruction memory: random ack delay; ack noise while no request is pending.
  int m_cnt = -1, m_del = 0;
  always begin
    @(posedge clk); #1;
    if (!imem_req) begin
      imem_ack = 1'($urandom_range(0, 1));
      m_cnt = -1;
    end else begin
      if (m_cnt < 0) begin
        m_del = $urandom_range(0, 3);
        m_cnt = 0;
      end else begin
        m_cnt++;
      end
      imem_data = mem[imem_addr];
      imem_ack  = (m_cnt == m_del);
      if (imem_ack) begin
        zero_flag = zf_tab[f_idx % 64];
        f_idx++;
      end
    end
  end

  // ALU: raises alu_done a table-chosen number of cycles after alu_start.
  int a_cnt = 0, a_lat = 0;
  always begin
    @(posedge clk); #1;
    if (alu_start) begin
      a_cnt = 0;
      a_lat = lat_tab[ex_idx % 64];
      ex_idx++;
    end else begin
      a_cnt++;
    end
    alu_done = (state == 3'd3) && (a_cnt == a_lat);
  end

  // Reference model: interprets the program one instruction at a time.
  task automatic build_model(input int n_max);
    int pc, ret, fi, ei, op, opnd;
    pc = 0; ret = 0; fi = 0; ei = 0;
    sbq.delete();
    for (int i = 0; i < n_max; i++) begin
      sbq.push_back('{K_FETCH, pc, ret});
      op   = int'(mem[pc][7:4]);
      opnd = int'(mem[pc][3:0]);
      pc   = (pc + 1) % 256;
      if (op == 15) begin
        sbq.push_back('{K_HALT, 0, ret});
        return;
      end else if (op == 14) begin
        pc = opnd * 16; ret = (ret + 1) % 65536;
      end else if (op == 13) begin
        if (zf_tab[fi]) pc = opnd * 16;
        ret = (ret + 1) % 65536;
      end else if (op == 0) begin
        ret = (ret + 1) % 65536;
      end else begin
        if (lat_tab[ei] >= TO) begin
          sbq.push_back('{K_HALT, 1, ret});
          return;
        end
        sbq.push_back('{K_WB, opnd, ret});
        ret = (ret + 1) % 65536;
        ei++;
      end
      fi++;
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT shows a fetch, writeback or halt.
  always @(negedge clk) begin
    if (sb_on && !reset) begin
      if (imem_req && imem_ack) begin
        if (sbq.size() == 0) check("sb_empty_fetch", 1, 0);
        else begin
          mon_e = sbq.pop_front();
          check("fetch_kind", mon_e.kind, K_FETCH);
          check("fetch_addr", imem_addr, mon_e.val);
          check("fetch_retired", retired, mon_e.ret);
        end
      end
      if (rf_we) begin
        if (sbq.size() == 0) check("sb_empty_wb", 1, 0);
        else begin
          mon_e = sbq.pop_front();
          check("wb_kind", mon_e.kind, K_WB);
          check("wb_waddr", rf_waddr, mon_e.val);
          check("wb_retired", retired, mon_e.ret);
        end
      end else begin
        check("waddr_zero", rf_waddr, 0);
      end
      if (halted && !halt_seen) begin
        halt_seen = 1;
        if (sbq.size() == 0) check("sb_empty_halt", 1, 0);
        else begin
          mon_e = sbq.pop_front();
          check("halt_kind", mon_e.kind, K_HALT);
          check("halt_err", err, mon_e.val);
          check("halt_retired", retired, mon_e.ret);
        end
      end
      if (halted) begin
        check("halt_state", state, 5);
        check("halt_quiet", {imem_req, rf_we, alu_start}, 0);
      end
      check("alu_start_pulse", alu_start, (state == 3'd3) && (prev_state != 3'd3));
      check("raddr", rf_raddr, ir[3:0]);
    end
    prev_state = state;
  end

  task automatic go_reset();
    reset = 1; run = 0; w_run = 0; sb_on = 0;
    repeat (2) @(posedge clk);
    #2;
    f_idx = 0; ex_idx = 0; halt_seen = 0;
  endtask

  task automatic wait_state(input logic [2:0] s, input string name);
    int c;
    c = 0;
    while (state !== s && c < 200) begin
      @(posedge clk); #2;
      c++;
    end
    if (c >= 200) check(name, state, s);
  endtask

  initial begin
    int c, op;
    n_chk = 0; n_fail = 0;
    imem_ack = 0; imem_data = 0; alu_done = 0; zero_flag = 0;
    reset = 1; run = 1; w_run = 0; sb_on = 0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_state", state, 0);
    check("rst_outs", {imem_req, rf_we, alu_start, halted, err}, 0);
    check("rst_addr", imem_addr, 0);
    check("rst_ir", ir, 0);
    check("rst_waddr", rf_waddr, 0);
    check("rst_retired", retired, 0);
    check("rst_wrap_addr", w_imem_addr, 8'hFF);

    // After reset, nothing happens until run is seen in IDLE.
    go_reset();
    reset = 0;
    c = 0;
    repeat (6) begin @(negedge clk); c += int'(imem_req); end
    check("idle_no_fetch", c, 0);
    check("idle_state", state, 0);

    // Random programs against the reference model.
    for (int r = 0; r < 8; r++) begin
      go_reset();
      for (int a = 0; a < 256; a++) begin
        op = $urandom_range(0, 15);
        if (op == 15 && $urandom_range(0, 3) != 0) op = 1;
        mem[a] = {4'(op), 4'($urandom_range(0, 15))};
      end
      for (int k = 0; k < 64; k++) begin
        zf_tab[k] = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 9))
          0: lat_tab[k] = TO - 1;
          1: lat_tab[k] = TO + $urandom_range(0, 2);
          default: lat_tab[k] = $urandom_range(0, 3);
        endcase
      end
      build_model(40);
      sb_on = 1; run = 1; reset = 0;
      c = 0;
      while (sbq.size() != 0 && c < 3000) begin
        @(posedge clk);
        c++;
      end
      #2;
      check("sb_drain", sbq.size(), 0);
      if (halt_seen) begin
        repeat (4) @(negedge clk);
        check("halt_sticky", {state, halted}, {3'd5, 1'b1});
      end
      sb_on = 0;
    end

    // Reset landing between edges in the middle of a long EXEC.
    go_reset();
    mem[0] = 8'h23; lat_tab[0] = 100;
    run = 1; reset = 0;
    wait_state(3'd3, "reach_exec");
    @(posedge clk); #3;
    reset = 1;
    #1;
    check("async_state", state, 0);
    check("async_alu_start", alu_start, 0);
    check("async_pc", imem_addr, 0);
    check("async_req", imem_req, 0);

    // run dropped mid-instruction: WB still happens, then IDLE with no more fetches.
    go_reset();
    mem[0] = 8'h23; lat_tab[0] = 0;
    run = 1; reset = 0;
    wait_state(3'd3, "reach_exec2");
    run = 0;
    wait_state(3'd4, "reach_wb");
    check("wb_we", {rf_we, rf_waddr}, {1'b1, 4'h3});
    @(posedge clk); #2;
    check("wb_to_idle", state, 0);
    check("wb_retired1", retired, 1);
    c = 0;
    repeat (10) begin @(negedge clk); c += int'(imem_req); end
    check("idle_after_wb", c, 0);

    // Address wrap from 8'hFF to 8'h00 on the NOP-only instance.
    go_reset();
    w_run = 1; reset = 0;
    c = 0;
    while (!w_imem_req && c < 20) begin @(negedge clk); c++; end
    check("wrap_fetch1", w_imem_addr, 8'hFF);
    @(negedge clk);
    c = 0;
    while (!w_imem_req && c < 20) begin @(negedge clk); c++; end
    check("wrap_fetch2", w_imem_addr, 8'h00);
    check("wrap_retired", w_retired, 1);
    go_reset();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_ctrl.md
CPU_CTRL -- requirements
Module: cpu_ctrl

Interface
REQ-001 Parameter RESET_PC, default 8'h00: PC value loaded on reset.
REQ-002 Parameter TIMEOUT, default 15: maximum EXEC cycles to wait for alu_done.
REQ-003 clk  in  1  single clock; all state changes on the rising edge.
REQ-004 reset  in  1  asynchronous, active-high; forces the reset state immediately, independent of clk.
REQ-005 run  in  1  level; permits instruction sequencing.
REQ-006 imem_req  out  1  instruction fetch request.
REQ-007 imem_addr  out  8  fetch address (= pc).
REQ-008 imem_ack  in  1  fetch data valid this cycle.
REQ-009 imem_data  in  8  instruction word.
REQ-010 ir  out  8  instruction register: [7:4] opcode, [3:0] operand.
REQ-011 rf_raddr  out  4  register read index; always = ir[3:0].
REQ-012 rf_we  out  1  register write enable.
REQ-013 rf_waddr  out  4  register write index.
REQ-014 alu_start  out  1  one-cycle execute pulse.
REQ-015 alu_done  in  1  execute result valid.
REQ-016 zero_flag  in  1  branch condition, sampled in DECODE.
REQ-017 state  out  3  FSM state: IDLE=0, FETCH=1, DECODE=2, EXEC=3, WB=4, HALT=5.
REQ-018 halted  out  1  high in HALT.
REQ-019 err  out  1  sticky ALU-timeout flag.
REQ-020 retired  out  16  count of completed instructions.

Function
REQ-021 IDLE: run=1 -> FETCH next edge; run=0 -> stay.
REQ-022 FETCH: imem_req=1, imem_addr=pc, held until imem_ack=1; on ack edge: ir<=imem_data, pc<=pc+1 (255 wraps to 0), -> DECODE.
REQ-023 DECODE is exactly one cycle; dispatch on ir[7:4]:
- 4'hF HALT -> HALT.
- 4'hE JMP: pc<={operand,4'h0}, retired+1, -> FETCH.
- 4'hD BZ: if zero_flag then pc<={operand,4'h0}; retired+1; -> FETCH.
- 4'h0 NOP: retired+1, -> FETCH.
- all other opcodes -> EXEC.
REQ-024 alu_start=1 for exactly the first EXEC cycle; 0 otherwise.
REQ-025 alu_done is sampled in every EXEC cycle, including the first; alu_done=1 -> WB.
REQ-026 A wait counter starts at 0 on EXEC entry; if alu_done is still 0 after TIMEOUT EXEC cycles -> HALT with err<=1 and no register write.
REQ-027 WB is one cycle: rf_we=1, rf_waddr=ir[3:0], retired+1; -> FETCH if run=1, else IDLE.
REQ-028 run is sampled only in IDLE and WB; deasserting run mid-instruction completes the current instruction.
REQ-029 HALT is absorbing: only reset exits it; imem_req=0, rf_we=0, alu_start=0.
REQ-030 rf_we=0 and rf_waddr=0 in every state except WB.
REQ-031 imem_ack outside FETCH is ignored.
REQ-032 retired wraps 16'hFFFF -> 0; HALT does not increment it.
REQ-033 The PC increment and the JMP/BZ target load never occur in the same cycle, because they happen in different states.

Reset
REQ-034 While reset=1: state=IDLE, pc=RESET_PC, ir=0, imem_req=0, imem_addr=RESET_PC, rf_we=0, rf_waddr=0, alu_start=0, halted=0, err=0, retired=0, wait counter=0.
REQ-035 Reset asserted mid-FETCH or mid-EXEC drops imem_req and alu_start in the same cycle (asynchronously); the pending fetch or execute is discarded.
REQ-036 After reset deasserts, the first FETCH occurs only after run=1 is sampled in IDLE.

Verification
REQ-037 Fetch stall: run=1, imem_data=8'h23, imem_ack delayed 3 cycles -> imem_req high for 4 cycles at addr 0; ir=8'h23 and pc=1 after the ack edge; then EXEC, then WB with rf_waddr=3; retired=1.
REQ-038 Jump: program 00:E5 -> next fetch address 8'h50; retired=1; no rf_we pulse.
REQ-039 Branch: BZ 8'hD7 with zero_flag=0 -> next fetch at pc+1; with zero_flag=1 -> next fetch at 8'h70.
REQ-040 Timeout: ALU opcode, alu_done held 0 -> after 15 EXEC cycles state=5, err=1, halted=1; no rf_we pulse; state stays 5 until reset.
REQ-041 Wrap: RESET_PC=8'hFF, NOP at FF -> second fetch address 8'h00.
REQ-042 Async reset: assert reset mid-EXEC between edges -> alu_start, state and pc return to reset values before the next clk edge; run=0 in WB -> IDLE and no further imem_req.
